// File: rtl/montgomery_reduce_tail_pkg.sv
// Shared constants, stage payload type and a reference reduction for the
// Montgomery reduction tail.
package montgomery_reduce_tail_pkg;

  localparam int unsigned       MR_WIDTH     = 32;
  localparam int unsigned       MR_TAG_WIDTH = 4;
  localparam logic [MR_WIDTH-1:0] MR_Q       = 32'd4294967291;
  // R = 2^WIDTH needs one bit more than an operand.
  localparam logic [MR_WIDTH:0] MR_R         = {1'b1, {MR_WIDTH{1'b0}}};

  // Payload carried through S1/S2: x holds m (zero-extended) in S1 and m*Q in S2.
  typedef struct packed {
    logic [2*MR_WIDTH-1:0]   t;
    logic [2*MR_WIDTH-1:0]   x;
    logic [MR_TAG_WIDTH-1:0] tag;
  } mr_stage_t;

  // Reference T*R^-1 mod Q given T and m = (T mod R)*Q' mod R.
  function automatic logic [MR_WIDTH-1:0] mr_reduce_ref(
    input logic [2*MR_WIDTH-1:0] t,
    input logic [MR_WIDTH-1:0]   m
  );
    logic [2*MR_WIDTH-1:0] mq;
    logic [2*MR_WIDTH:0]   sum;
    logic [MR_WIDTH:0]     u;
    mq  = {{MR_WIDTH{1'b0}}, m} * {{MR_WIDTH{1'b0}}, MR_Q};
    sum = {1'b0, t} + {1'b0, mq};
    u   = sum[2*MR_WIDTH:MR_WIDTH];
    if (u >= {1'b0, MR_Q}) return u[MR_WIDTH-1:0] - MR_Q;
    return u[MR_WIDTH-1:0];
  endfunction

  // Reference Q' mismatch flag: the low half of T + m*Q must be zero.
  function automatic logic mr_err_ref(
    input logic [2*MR_WIDTH-1:0] t,
    input logic [MR_WIDTH-1:0]   m
  );
    logic [2*MR_WIDTH-1:0] mq;
    logic [2*MR_WIDTH-1:0] sum;
    mq  = {{MR_WIDTH{1'b0}}, m} * {{MR_WIDTH{1'b0}}, MR_Q};
    sum = t + mq;
    return |sum[MR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/montgomery_reduce_tail_if.sv
// Valid/ready bundle for the reduction tail: operand side and result side.
interface montgomery_reduce_tail_if
  import montgomery_reduce_tail_pkg::*;
#(
  parameter int WIDTH     = MR_WIDTH,
  parameter int TAG_WIDTH = MR_TAG_WIDTH
);

  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     in_t;
  logic [2*WIDTH-1:0]     in_p;
  logic [TAG_WIDTH-1:0]   in_tag;

  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_r;
  logic [TAG_WIDTH-1:0]   out_tag;
  logic                   out_err;

  // Producer of operands / consumer of results (upstream + downstream).
  modport master (
    output in_valid, in_t, in_p, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag, out_err
  );

  // The reduction tail itself.
  modport slave (
    input  in_valid, in_t, in_p, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag, out_err
  );

endinterface

// File: rtl/SignedMultiplier.sv
// Generic combinational signed multiplier; full-width product.
module SignedMultiplier #(
  parameter int A_WIDTH = 33,
  parameter int B_WIDTH = 33
) (
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

  // Operands are sign-extended to the product width by the signed context.
  always_comb begin
    p = a * b;
  end

endmodule

// File: rtl/mont_cond_sub.sv
// Conditional subtract of the modulus from a (WIDTH+1)-bit value.
// Inputs are expected below 2Q, so one subtraction lands the result in [0, Q).
module mont_cond_sub
  import montgomery_reduce_tail_pkg::*;
#(
  parameter int               WIDTH = MR_WIDTH,
  parameter logic [WIDTH-1:0] Q     = MR_Q
) (
  input  logic [WIDTH:0]   a,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] diff;
  logic             take;

  // Compare on the full WIDTH+1 bits so the carry bit is honoured; the
  // difference itself always fits in WIDTH bits when a < 2Q.
  always_comb begin
    take = (a >= {1'b0, Q});
    diff = a[WIDTH-1:0] - Q;
    r    = take ? diff : a[WIDTH-1:0];
  end

endmodule

// File: rtl/montgomery_reduce_tail.sv
// Pipelined back end of Montgomery reduction: given T and the upstream
// product p (only m = p mod R used), returns T*R^-1 mod Q with valid/ready
// flow control, tag passthrough and a Q' mismatch flag.
//
// Pipeline: S1 (T, m, tag) -> S2 (T, m*Q, tag) -> S3 (T + m*Q, tag) -> out.
// Every register stage loads when it is empty or its successor is loading,
// so bubbles collapse and a full pipe holds four operations.
module montgomery_reduce_tail
  import montgomery_reduce_tail_pkg::*;
#(
  parameter int               WIDTH     = MR_WIDTH,
  parameter logic [WIDTH-1:0] Q         = MR_Q,
  parameter int               TAG_WIDTH = MR_TAG_WIDTH
) (
  input logic                     clk,
  input logic                     rst_n,
  montgomery_reduce_tail_if.slave io
);

  // Stage occupancy.
  logic v1;
  logic v2;
  logic v3;

  // Stage load enables, chained combinationally back from out_ready.
  logic ld1;
  logic ld2;
  logic ld3;
  logic ld_o;

  // Stage payloads. S1/S2 use the shared payload type; S3 carries the sum.
  mr_stage_t              s1;
  mr_stage_t              s2;
  logic [2*WIDTH:0]       s3_sum;
  logic [TAG_WIDTH-1:0]   s3_tag;

  // m*Q via the shared signed multiplier; the extra zero MSB keeps both
  // unsigned operands non-negative.
  logic signed [WIDTH:0]     mul_a;
  logic signed [WIDTH:0]     mul_b;
  logic signed [2*WIDTH+1:0] mq_full;

  // Reduced value u = sum >> WIDTH keeps the carry into bit 2*WIDTH.
  logic [WIDTH:0]   u;
  logic [WIDTH-1:0] r_next;
  logic             err_next;

  // High half of in_p and the top multiplier bits carry no information here.
  logic unused_bits;

  // Back-pressure chain: a stage may load if it is empty or its successor loads.
  always_comb begin
    ld_o = !io.out_valid || io.out_ready;
    ld3  = !v3 || ld_o;
    ld2  = !v2 || ld3;
    ld1  = !v1 || ld2;
  end

  assign io.in_ready = ld1;

  assign mul_a = $signed({1'b0, s1.x[WIDTH-1:0]});
  assign mul_b = $signed({1'b0, Q});

  SignedMultiplier #(
    .A_WIDTH (WIDTH + 1),
    .B_WIDTH (WIDTH + 1)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mq_full)
  );

  assign u        = s3_sum[2*WIDTH:WIDTH];
  assign err_next = |s3_sum[WIDTH-1:0];

  mont_cond_sub #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_csub (
    .a (u),
    .r (r_next)
  );

  assign unused_bits = ^{io.in_p[2*WIDTH-1:WIDTH],
                         s1.x[2*WIDTH-1:WIDTH],
                         mq_full[2*WIDTH+1:2*WIDTH]};

  // Stage valid bits: reset clears all in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= io.in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  // Datapath registers are unreset and only load when real data moves in.
  always_ff @(posedge clk) begin
    if (ld1 && io.in_valid) begin
      s1.t   <= io.in_t;
      s1.x   <= {{WIDTH{1'b0}}, io.in_p[WIDTH-1:0]};
      s1.tag <= io.in_tag;
    end
    if (ld2 && v1) begin
      s2.t   <= s1.t;
      s2.x   <= mq_full[2*WIDTH-1:0];
      s2.tag <= s1.tag;
    end
    if (ld3 && v2) begin
      s3_sum <= {1'b0, s2.t} + {1'b0, s2.x};
      s3_tag <= s2.tag;
    end
  end

  // Output stage: reset to zero, holds steady while stalled by out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.out_r     <= '0;
      io.out_tag   <= '0;
      io.out_err   <= 1'b0;
    end else if (ld_o) begin
      io.out_valid <= v3;
      if (v3) begin
        io.out_r   <= r_next;
        io.out_tag <= s3_tag;
        io.out_err <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_montgomery_reduce_tail.sv
// Directed and randomised checks for montgomery_reduce_tail.
// Random results are checked via the defining property r*R == T (mod Q),
// with R mod Q = 5 for this modulus, independent of the datapath structure.
module tb_montgomery_reduce_tail;
  import montgomery_reduce_tail_pkg::*;

  localparam int          W    = MR_WIDTH;
  localparam int          TW   = MR_TAG_WIDTH;
  localparam logic [31:0] QP   = 32'hCCCCCCCD;  // Q*Q' == -1 mod 2^32
  localparam int          NMAX = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   edge_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  montgomery_reduce_tail_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus ();

  montgomery_reduce_tail dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  logic [2*W-1:0] st_t   [NMAX];
  logic [W-1:0]   st_m   [NMAX];
  logic [TW-1:0]  st_tag [NMAX];
  logic [W-1:0]   got_r   [NMAX];
  logic [TW-1:0]  got_tag [NMAX];
  logic           got_err [NMAX];
  int             got_edge [NMAX];
  int             acc_edge [NMAX];

  int n_pass  = 0;
  int n_total = 0;

  task automatic set_op(input int i, input logic [2*W-1:0] t, input logic [W-1:0] m,
                        input logic [TW-1:0] tag);
    st_t[i] = t; st_m[i] = m; st_tag[i] = tag;
  endtask

  task automatic gen_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] hi;
      logic [31:0] lo;
      hi = $urandom_range(MR_Q - 1, 0);
      lo = $urandom;
      st_t[i]   = {hi, lo};
      st_m[i]   = lo * QP;
      st_tag[i] = TW'($urandom);
    end
  endtask

  // Drives n ops back to back and records every emitted result; starts and
  // ends just after a rising edge.
  task automatic pump(input int n, input bit rand_rdy, input int max_cyc, output int ngot);
    int sent = 0;
    int cyc  = 0;
    ngot = 0;
    while (ngot < n && cyc < max_cyc) begin
      bus.in_valid = (sent < n);
      if (sent < n) begin
        bus.in_t   = st_t[sent];
        bus.in_p   = {st_t[sent][31:0] ^ 32'hA5A55A5A, st_m[sent]};
        bus.in_tag = st_tag[sent];
      end
      bus.out_ready = rand_rdy ? ($urandom_range(3, 0) != 0) : 1'b1;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        acc_edge[sent] = edge_n + 1;
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_r[ngot]    = bus.out_r;
        got_tag[ngot]  = bus.out_tag;
        got_err[ngot]  = bus.out_err;
        got_edge[ngot] = edge_n;
        ngot++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_r !== '0) $display("FAIL reset_out_r: got %h expected 0", bus.out_r); else n_pass++;
    n_total++; if (bus.out_tag !== '0) $display("FAIL reset_out_tag: got %h expected 0", bus.out_tag); else n_pass++;
    n_total++; if (bus.out_err !== 1'b0) $display("FAIL reset_out_err: got %b expected 0", bus.out_err); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_latency;
    int ngot;
    set_op(0, 64'h0, 32'h0, 4'h3);
    pump(1, 1'b0, 20, ngot);
    n_total++; if (ngot !== 1) $display("FAIL zero_count: got %0d expected 1", ngot); else n_pass++;
    n_total++; if (got_r[0] !== 32'h0) $display("FAIL zero_r: got %h expected 0", got_r[0]); else n_pass++;
    n_total++; if (got_err[0] !== 1'b0) $display("FAIL zero_err: got %b expected 0", got_err[0]); else n_pass++;
    n_total++; if (got_tag[0] !== 4'h3) $display("FAIL zero_tag: got %h expected 3", got_tag[0]); else n_pass++;
    n_total++; if (got_edge[0] - acc_edge[0] !== 3) $display("FAIL zero_latency: got %0d expected 3", got_edge[0] - acc_edge[0]); else n_pass++;
  endtask

  task automatic test_boundaries;
    int ngot;
    logic [W-1:0] exp_r [6];
    set_op(0, 64'h0000_0000_FFFF_FFFB, 32'hFFFF_FFFF, 4'h1); exp_r[0] = 32'h0;         // u = Q exactly
    set_op(1, 64'(MR_R),               32'h0,         4'h2); exp_r[1] = 32'h1;         // T = R
    set_op(2, 64'hFFFF_FFFA_FFFF_FFFF, 32'h3333_3333, 4'h3); exp_r[2] = 32'h3333_3332; // T = Q*R-1, carry kept
    set_op(3, 64'h5,                   32'h1,         4'h4); exp_r[3] = 32'h1;
    set_op(4, 64'h3_0000_0000,         32'h0,         4'h5); exp_r[4] = 32'h3;
    set_op(5, 64'h1_0000_0001,         32'hCCCC_CCCD, 4'h6); exp_r[5] = 32'hCCCC_CCCA;
    pump(6, 1'b0, 40, ngot);
    n_total++; if (ngot !== 6) $display("FAIL bound_count: got %0d expected 6", ngot); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (got_r[i] !== exp_r[i]) $display("FAIL bound_r[%0d]: got %h expected %h", i, got_r[i], exp_r[i]); else n_pass++;
      n_total++; if (got_err[i] !== 1'b0) $display("FAIL bound_err[%0d]: got %b expected 0", i, got_err[i]); else n_pass++;
      n_total++; if (got_tag[i] !== st_tag[i]) $display("FAIL bound_tag[%0d]: got %h expected %h", i, got_tag[i], st_tag[i]); else n_pass++;
    end
  endtask

  task automatic test_err_flag;
    int ngot;
    logic [W-1:0] exp_r [3];
    logic         exp_e [3];
    set_op(0, 64'h0, 32'h0, 4'hA); exp_r[0] = 32'h0; exp_e[0] = 1'b0;
    set_op(1, 64'h1, 32'h0, 4'hB); exp_r[1] = 32'h0; exp_e[1] = 1'b1;
    set_op(2, 64'h5, 32'h1, 4'hC); exp_r[2] = 32'h1; exp_e[2] = 1'b0;
    pump(3, 1'b0, 30, ngot);
    n_total++; if (ngot !== 3) $display("FAIL err_count: got %0d expected 3", ngot); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (got_err[i] !== exp_e[i]) $display("FAIL err_flag[%0d]: got %b expected %b", i, got_err[i], exp_e[i]); else n_pass++;
      n_total++; if (got_r[i] !== exp_r[i]) $display("FAIL err_r[%0d]: got %h expected %h", i, got_r[i], exp_r[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back(input int n, input bit rand_rdy);
    int ngot;
    logic [63:0] lhs;
    logic [63:0] rhs;
    gen_random(n);
    pump(n, rand_rdy, n * 8 + 50, ngot);
    n_total++; if (ngot !== n) $display("FAIL b2b_count: got %0d expected %0d", ngot, n); else n_pass++;
    for (int k = 0; k < ngot; k++) begin
      lhs = ({32'h0, got_r[k]} * 64'd5) % {32'h0, MR_Q};
      rhs = st_t[k] % {32'h0, MR_Q};
      n_total++;
      if (got_r[k] >= MR_Q || lhs !== rhs)
        $display("FAIL b2b_r[%0d]: got %h for T=%h (r*5 mod Q %h, T mod Q %h)", k, got_r[k], st_t[k], lhs, rhs);
      else n_pass++;
      n_total++; if (got_tag[k] !== st_tag[k]) $display("FAIL b2b_tag[%0d]: got %h expected %h", k, got_tag[k], st_tag[k]); else n_pass++;
      n_total++; if (got_err[k] !== 1'b0) $display("FAIL b2b_err[%0d]: got %b expected 0", k, got_err[k]); else n_pass++;
      if (!rand_rdy) begin
        n_total++; if (got_edge[k] - acc_edge[k] !== 3) $display("FAIL b2b_latency[%0d]: got %0d expected 3", k, got_edge[k] - acc_edge[k]); else n_pass++;
        n_total++; if (got_edge[k] - got_edge[0] !== k) $display("FAIL b2b_rate[%0d]: got %0d expected %0d", k, got_edge[k] - got_edge[0], k); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int ngot = 0;
    bit seen = 1'b0;
    logic [W-1:0]  hold_r;
    logic [TW-1:0] hold_tag;
    logic          hold_err;
    logic [63:0]   lhs;
    logic [63:0]   rhs;
    gen_random(6);
    for (int i = 0; i < 6; i++) st_tag[i] = TW'(i + 1);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (sent < 6);
      if (sent < 6) begin
        bus.in_t = st_t[sent]; bus.in_p = {32'h0, st_m[sent]}; bus.in_tag = st_tag[sent];
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid) begin
        if (!seen) begin
          hold_r = bus.out_r; hold_tag = bus.out_tag; hold_err = bus.out_err; seen = 1'b1;
        end else begin
          n_total++;
          if ({bus.out_r, bus.out_tag, bus.out_err} !== {hold_r, hold_tag, hold_err})
            $display("FAIL bp_stable: got %h/%h/%b expected %h/%h/%b", bus.out_r, bus.out_tag, bus.out_err, hold_r, hold_tag, hold_err);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_total++; if (sent !== 4) $display("FAIL bp_accepted: got %0d expected 4", sent); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", bus.out_valid); else n_pass++;
    @(posedge clk); #1;
    for (int c = 0; c < 30 && ngot < 6; c++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < 6);
      if (sent < 6) begin
        bus.in_t = st_t[sent]; bus.in_p = {32'h0, st_m[sent]}; bus.in_tag = st_tag[sent];
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid) begin
        got_r[ngot] = bus.out_r; got_tag[ngot] = bus.out_tag; ngot++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_total++; if (ngot !== 6) $display("FAIL bp_count: got %0d expected 6", ngot); else n_pass++;
    for (int k = 0; k < ngot; k++) begin
      lhs = ({32'h0, got_r[k]} * 64'd5) % {32'h0, MR_Q};
      rhs = st_t[k] % {32'h0, MR_Q};
      n_total++; if (got_tag[k] !== st_tag[k]) $display("FAIL bp_tag[%0d]: got %h expected %h", k, got_tag[k], st_tag[k]); else n_pass++;
      n_total++; if (lhs !== rhs) $display("FAIL bp_r[%0d]: got %h (r*5 mod Q %h, T mod Q %h)", k, got_r[k], lhs, rhs); else n_pass++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup: got out_valid %b expected 0", bus.out_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight;
    int ngot;
    bit stale = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_t = 64'h5; bus.in_p = 64'h1; bus.in_tag = TW'(7 + i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      stale |= bus.out_valid;
      @(posedge clk); #1;
    end
    n_total++; if (stale !== 1'b0) $display("FAIL rst_mid_stale: got out_valid %b expected 0", stale); else n_pass++;
    set_op(0, 64'h5, 32'h1, 4'hD);
    pump(1, 1'b0, 20, ngot);
    n_total++; if (ngot !== 1) $display("FAIL rst_mid_count: got %0d expected 1", ngot); else n_pass++;
    n_total++; if (got_tag[0] !== 4'hD) $display("FAIL rst_mid_tag: got %h expected d", got_tag[0]); else n_pass++;
    n_total++; if (got_r[0] !== 32'h1) $display("FAIL rst_mid_r: got %h expected 1", got_r[0]); else n_pass++;
    n_total++; if (got_edge[0] - acc_edge[0] !== 3) $display("FAIL rst_mid_latency: got %0d expected 3", got_edge[0] - acc_edge[0]); else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_t      = '0;
    bus.in_p      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_zero_latency();
    test_boundaries();
    test_err_flag();
    test_back_to_back(NMAX, 1'b0);
    test_back_to_back(400, 1'b1);
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
